// File: rtl/pipe_ctrl.sv
// Pipeline hazard/interrupt controller: load-use stalls, branch flushes, drained interrupt injection.
// Latency: stall/flush/inject outputs are combinational (0 cycles); FSM, drain counter, stall counter registered.
// Backpressure: none; a load-use hazard holds PC and IF/ID for one cycle, and DRAIN holds PC for DRAIN_CYCLES cycles.
module pipe_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             interrupt,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             branch_sel,
    input  logic             ex_mem_rd,
    input  logic [3:0]       ex_reg_dst,
    input  logic             ex_returni,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             int_inject,
    output logic             int_active,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        INJECT = 2'd2,
        ISR    = 2'd3
    } state_t;

    // Three bits cover the whole legal DRAIN_CYCLES range of 1..7.
    localparam int unsigned      DC_W       = 3;
    localparam logic [DC_W-1:0]  DRAIN_LOAD = DC_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic hazard_window;
    logic load_use;
    logic branch_take;
    logic in_drain;
    logic in_inject;

    // Hazard decode: only meaningful while normal instructions flow (IDLE or ISR);
    // a load-use hazard masks the branch because the held ID instruction re-presents it.
    always_comb begin
        hazard_window = (state_q == IDLE) || (state_q == ISR);
        load_use      = hazard_window && ex_mem_rd &&
                        ((ex_reg_dst == id_rs1) || (ex_reg_dst == id_rs2));
        branch_take   = hazard_window && branch_sel && !load_use;
        in_drain      = (state_q == DRAIN);
        in_inject     = (state_q == INJECT);
    end

    // Next-state logic for the interrupt sequencer, drain counter and stall counter.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        stall_count_d = stall_count_q;

        case (state_q)
            IDLE: begin
                // Only start draining on a quiet cycle so a pending stall or flush completes first.
                if (interrupt && !load_use && !branch_sel) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = INJECT;
                end else begin
                    drain_cnt_d = drain_cnt_q - DC_W'(1);
                end
            end
            INJECT: begin
                state_d = ISR;
            end
            ISR: begin
                // Interrupt is masked here; only returni leaves the handler.
                if (ex_returni) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_use && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // Register state; synchronous reset drops any sequence in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            drain_cnt_q   <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Pipeline control outputs, forced low while reset is asserted.
    always_comb begin
        pc_stall    = !rst && (load_use || in_drain);
        if_id_stall = !rst && load_use;
        id_ex_flush = !rst && load_use;
        if_id_flush = !rst && (branch_take || in_drain);
        int_inject  = !rst && in_inject;
        int_active  = !rst && (state_q != IDLE);
        stall_count = rst ? '0 : stall_count_q;
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, saturation sequence, randomized traffic.
// Two instances: defaults (DRAIN_CYCLES=3, CNT_W=16) and a corner build (DRAIN_CYCLES=1, CNT_W=4).
// Inputs driven on the falling edge, outputs sampled 1ns later.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        interrupt;
    logic [3:0]  id_rs1;
    logic [3:0]  id_rs2;
    logic        branch_sel;
    logic        ex_mem_rd;
    logic [3:0]  ex_reg_dst;
    logic        ex_returni;

    logic        a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_int_inject, a_int_active;
    logic [15:0] a_stall_count;
    logic        b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_int_inject, b_int_active;
    logic [3:0]  b_stall_count;

    int checks = 0;
    int errors = 0;

    localparam int D_A   = 3;
    localparam int MAX_A = 65535;
    localparam int D_B   = 1;
    localparam int MAX_B = 15;

    // Reference model: position in the interrupt sequence (0 idle, 1..D draining,
    // D+1 inject, D+2 handler) and the stall count as a plain integer.
    int pos_a = 0, cnt_a = 0;
    int pos_b = 0, cnt_b = 0;

    pipe_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .interrupt(interrupt), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .branch_sel(branch_sel), .ex_mem_rd(ex_mem_rd), .ex_reg_dst(ex_reg_dst),
        .ex_returni(ex_returni), .pc_stall(a_pc_stall), .if_id_stall(a_if_id_stall),
        .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush), .int_inject(a_int_inject),
        .int_active(a_int_active), .stall_count(a_stall_count)
    );

    pipe_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .interrupt(interrupt), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .branch_sel(branch_sel), .ex_mem_rd(ex_mem_rd), .ex_reg_dst(ex_reg_dst),
        .ex_returni(ex_returni), .pc_stall(b_pc_stall), .if_id_stall(b_if_id_stall),
        .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush), .int_inject(b_int_inject),
        .int_active(b_int_active), .stall_count(b_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        rst;
        logic        intr;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic        br;
        logic        mrd;
        logic [3:0]  dst;
        logic        reti;
        logic [5:0]  exp_o;   // {pc_stall, if_id_stall, if_id_flush, id_ex_flush, int_inject, int_active}
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t tbl [21];

    function automatic vec_t mk(logic r, logic i, logic [3:0] s1, logic [3:0] s2, logic b,
                                logic m, logic [3:0] d, logic rt, logic [5:0] eo, logic [15:0] ec);
        vec_t v;
        v.rst = r; v.intr = i; v.rs1 = s1; v.rs2 = s2; v.br = b;
        v.mrd = m; v.dst = d; v.reti = rt; v.exp_o = eo; v.exp_cnt = ec;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst        = v.rst;
        interrupt  = v.intr;
        id_rs1     = v.rs1;
        id_rs2     = v.rs2;
        branch_sel = v.br;
        ex_mem_rd  = v.mrd;
        ex_reg_dst = v.dst;
        ex_returni = v.reti;
    endtask

    function automatic bit model_lu(int pos, int d);
        bit hw;
        hw = (pos == 0) || (pos == d + 2);
        return hw && ex_mem_rd && ((ex_reg_dst == id_rs1) || (ex_reg_dst == id_rs2));
    endfunction

    function automatic logic [5:0] model_out(int pos, int d);
        bit lu, br, dr, hw;
        if (rst) return 6'b0;
        hw = (pos == 0) || (pos == d + 2);
        lu = model_lu(pos, d);
        br = hw && branch_sel && !lu;
        dr = (pos >= 1) && (pos <= d);
        return {lu || dr, lu, br || dr, lu, pos == d + 1, pos != 0};
    endfunction

    function automatic int model_next_pos(int pos, int d);
        if (rst) return 0;
        if (pos == 0) return (interrupt && !model_lu(pos, d) && !branch_sel) ? 1 : 0;
        if (pos < d + 2) return pos + 1;
        return ex_returni ? 0 : pos;
    endfunction

    function automatic int model_next_cnt(int pos, int d, int cnt, int maxc);
        if (rst) return 0;
        if (model_lu(pos, d)) return (cnt < maxc) ? cnt + 1 : cnt;
        return cnt;
    endfunction

    task automatic check(input string name, input logic [5:0] got_o, input logic [5:0] exp_o,
                         input logic [15:0] got_c, input logic [15:0] exp_c);
        checks++;
        if (got_o !== exp_o || got_c !== exp_c) begin
            errors++;
            $display("FAIL %s: got outs=%b count=%0d, expected outs=%b count=%0d",
                     name, got_o, got_c, exp_o, exp_c);
        end
    endtask

    // Compare both instances with the model for the currently driven inputs, then advance the model.
    task automatic step(input string tag);
        logic [5:0] ga, gb;
        ga = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_int_inject, a_int_active};
        gb = {b_pc_stall, b_if_id_stall, b_if_id_flush, b_id_ex_flush, b_int_inject, b_int_active};
        check({tag, "/model_a"}, ga, model_out(pos_a, D_A), a_stall_count,
              rst ? 16'd0 : 16'(cnt_a));
        check({tag, "/model_b"}, gb, model_out(pos_b, D_B), {12'd0, b_stall_count},
              rst ? 16'd0 : 16'(cnt_b));
        cnt_a = model_next_cnt(pos_a, D_A, cnt_a, MAX_A);
        pos_a = model_next_pos(pos_a, D_A);
        cnt_b = model_next_cnt(pos_b, D_B, cnt_b, MAX_B);
        pos_b = model_next_pos(pos_b, D_B);
    endtask

    initial begin
        vec_t idle_v;
        vec_t lu_v;
        logic [5:0] ga;

        idle_v = mk(0, 0, 4'd0, 4'd0, 0, 0, 4'd9, 0, 6'b0, 16'd0);
        rst = 1'b1;
        interrupt = 1'b0; id_rs1 = '0; id_rs2 = '0; branch_sel = 1'b0;
        ex_mem_rd = 1'b0; ex_reg_dst = '0; ex_returni = 1'b0;

        //            rst int rs1    rs2    br mrd dst    reti exp_o      cnt
        tbl[0]  = mk(1,  1,  4'd0,  4'd5,  1, 1,  4'd5,  0,  6'b000000, 16'd0); // reset masks everything
        tbl[1]  = mk(0,  0,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd0);
        tbl[2]  = mk(0,  0,  4'd0,  4'd5,  0, 1,  4'd5,  0,  6'b110100, 16'd0); // load-use on rs2
        tbl[3]  = mk(0,  0,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd1);
        tbl[4]  = mk(0,  0,  4'd3,  4'd0,  1, 1,  4'd3,  0,  6'b110100, 16'd1); // branch hidden by hazard
        tbl[5]  = mk(0,  0,  4'd3,  4'd0,  1, 0,  4'd3,  0,  6'b001000, 16'd2); // branch flush
        tbl[6]  = mk(0,  0,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd2);
        tbl[7]  = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd2); // interrupt seen in IDLE
        tbl[8]  = mk(0,  1,  4'd5,  4'd0,  1, 1,  4'd5,  0,  6'b101001, 16'd2); // drain 1, traffic ignored
        tbl[9]  = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b101001, 16'd2); // drain 2
        tbl[10] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b101001, 16'd2); // drain 3
        tbl[11] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  1,  6'b000011, 16'd2); // inject, returni ignored
        tbl[12] = mk(0,  1,  4'd0,  4'd0,  1, 0,  4'd9,  0,  6'b001001, 16'd2); // ISR branch
        tbl[13] = mk(0,  1,  4'd5,  4'd0,  0, 1,  4'd5,  0,  6'b110101, 16'd2); // ISR load-use
        tbl[14] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000001, 16'd3); // masked, no re-inject
        tbl[15] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  1,  6'b000001, 16'd3); // returni
        tbl[16] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd3); // back in IDLE
        tbl[17] = mk(0,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b101001, 16'd3); // re-sequence drain 1
        tbl[18] = mk(1,  1,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd0); // reset during drain 2
        tbl[19] = mk(0,  0,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd0); // idle, no inject
        tbl[20] = mk(0,  0,  4'd0,  4'd0,  0, 0,  4'd9,  0,  6'b000000, 16'd0);

        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            ga = {a_pc_stall, a_if_id_stall, a_if_id_flush, a_id_ex_flush, a_int_inject, a_int_active};
            check($sformatf("vec[%0d]", i), ga, tbl[i].exp_o, a_stall_count, tbl[i].exp_cnt);
            step($sformatf("vec[%0d]", i));
        end

        // Saturation: 17 back-to-back hazards after a reset.
        @(negedge clk);
        drive(idle_v);
        rst = 1'b1;
        #1;
        step("sat_reset");
        lu_v = mk(0, 0, 4'd0, 4'd5, 0, 1, 4'd5, 0, 6'b0, 16'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(lu_v);
            #1;
            check($sformatf("sat_cnt[%0d]", i), 6'b0, 6'b0, {12'd0, b_stall_count},
                  16'((i < 15) ? i : 15));
            step($sformatf("sat[%0d]", i));
        end
        @(negedge clk);
        drive(idle_v);
        #1;
        check("sat_final_b", 6'b0, 6'b0, {12'd0, b_stall_count}, 16'd15);
        check("sat_final_a", 6'b0, 6'b0, a_stall_count, 16'd17);
        step("sat_idle");

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 99) == 0);
            interrupt  = ($urandom_range(0, 3) != 0);
            id_rs1     = 4'($urandom_range(0, 3));
            id_rs2     = 4'($urandom_range(0, 3));
            ex_reg_dst = 4'($urandom_range(0, 3));
            ex_mem_rd  = ($urandom_range(0, 1) == 1);
            branch_sel = ($urandom_range(0, 3) == 0);
            ex_returni = ($urandom_range(0, 7) == 0);
            #1;
            step($sformatf("rand[%0d]", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3: bubble cycles inserted before interrupt injection; legal range 1..7.
REQ-002 SHALL have parameter CNT_W, default 16: width of the stall performance counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 interrupt  input  1  external interrupt request, level; held until serviced.
REQ-006 id_rs1  input  4  source register 1 of instruction in ID.
REQ-007 id_rs2  input  4  source register 2 of instruction in ID.
REQ-008 branch_sel  input  1  ID decoded taken branch/jump this cycle.
REQ-009 ex_mem_rd  input  1  instruction in EX is a load that writes a register.
REQ-010 ex_reg_dst  input  4  destination register of instruction in EX.
REQ-011 ex_returni  input  1  returni in EX this cycle, 1-cycle pulse.
REQ-012 pc_stall  output  1  hold PC.
REQ-013 if_id_stall  output  1  hold IF/ID buffer.
REQ-014 if_id_flush  output  1  load bubble into IF/ID buffer.
REQ-015 id_ex_flush  output  1  load bubble into ID/EX register.
REQ-016 int_inject  output  1  IF inserts the interrupt instruction this cycle, 1-cycle pulse.
REQ-017 int_active  output  1  interrupt sequence or ISR in progress.
REQ-018 stall_count  output  CNT_W  saturating count of load-use stall cycles.

Function
REQ-019 SHALL implement FSM states IDLE, DRAIN, INJECT, ISR.
REQ-020 SHALL define load_use = ex_mem_rd && (ex_reg_dst == id_rs1 || ex_reg_dst == id_rs2), evaluated combinationally in IDLE and ISR only.
REQ-021 SHALL, when load_use, assert pc_stall, if_id_stall, id_ex_flush in the same cycle; stall lasts exactly 1 cycle per hazard (bubble clears ex_mem_rd next cycle).
REQ-022 SHALL, when load_use, ignore branch_sel that cycle (held ID instruction re-presents it next cycle).
REQ-023 SHALL, when branch_sel and not load_use, assert if_id_flush for that cycle only; pc_stall stays 0.
REQ-024 SHALL in IDLE transition to DRAIN when interrupt=1 and neither load_use nor branch_sel is active; otherwise remain IDLE.
REQ-025 SHALL in DRAIN assert pc_stall and if_id_flush every cycle, load drain counter to DRAIN_CYCLES-1 on entry, decrement each cycle, go to INJECT when counter is 0 (DRAIN occupies exactly DRAIN_CYCLES cycles).
REQ-026 SHALL ignore branch_sel, ex_mem_rd and ex_returni while in DRAIN and INJECT.
REQ-027 SHALL in INJECT assert int_inject for exactly 1 cycle, pc_stall=0, then go to ISR unconditionally.
REQ-028 SHALL in ISR ignore interrupt; handle load_use and branch_sel as in IDLE; return to IDLE on ex_returni.
REQ-029 SHALL, if interrupt is still high on the cycle after return to IDLE, start a new sequence per REQ-024 (no extra masking).
REQ-030 SHALL drive int_active=1 in DRAIN, INJECT, ISR; 0 in IDLE.
REQ-031 SHALL increment stall_count by 1 on every cycle REQ-021 asserts a stall; saturate at 2^CNT_W-1, never wrap.
REQ-032 SHALL generate all stall/flush/inject outputs combinationally from current state and inputs (0-cycle latency); FSM and counters registered.

Reset
REQ-033 SHALL on rst=1 at a clock edge enter IDLE, clear drain counter and stall_count, regardless of state (including mid-DRAIN or ISR).
REQ-034 SHALL hold all outputs 0 while rst=1 irrespective of other inputs.
REQ-035 SHALL discard a pending interrupt sequence on reset; interrupt still high after release restarts at REQ-024.

Verification
REQ-036 Load-use: ex_mem_rd=1, ex_reg_dst=5, id_rs2=5 one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_count 0->1.
REQ-037 Branch vs hazard: branch_sel=1 with load_use=1 -> no if_id_flush; next cycle branch_sel=1, load_use=0 -> if_id_flush=1 for 1 cycle.
REQ-038 Interrupt, DRAIN_CYCLES=3: interrupt rises in IDLE -> pc_stall+if_id_flush cycles 1-3, int_inject=1 cycle 4, int_active=1 from cycle 1 until ex_returni cycle.
REQ-039 Masking: interrupt held high through ISR with branch and load-use traffic -> no second int_inject until after ex_returni; re-sequence starts the following cycle.
REQ-040 Reset mid-DRAIN: rst=1 during DRAIN cycle 2 -> next cycle all outputs 0, state IDLE, int_inject never pulses.
REQ-041 Saturation, CNT_W=4: 17 consecutive hazard cycles -> stall_count reaches 15 and stays 15.
